// File: rtl/mp_reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package mp_reg_file_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_NUM_RD = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/mp_reg_file_clr_fsm.sv
// Background clear sequencer: walks every register index once, then pulses done.
module mp_reg_file_clr_fsm
    import mp_reg_file_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] idx,
    output logic              clr_stb
);

    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    clr_state_e state;

    // State, index and registered status outputs; reset aborts any sweep silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            clr_stb <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_SWEEP;
                        idx     <= '0;
                        busy    <= 1'b1;
                        clr_stb <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    idx <= idx + ADDR_W'(1);
                    if (idx == LAST) begin
                        state   <= ST_DONE;
                        clr_stb <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    clr_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mp_reg_file.sv
// Two-write, NUM_RD-read register file with optional forwarding, zero register
// and a background clear sweep that locks out writes while it runs.
module mp_reg_file
    import mp_reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     WE0,
    input  logic                     WE1,
    input  logic [ADDR_W-1:0]        WADDR0,
    input  logic [ADDR_W-1:0]        WADDR1,
    input  logic [DATA_W-1:0]        WDATA0,
    input  logic [DATA_W-1:0]        WDATA1,
    input  logic [NUM_RD*ADDR_W-1:0] RADDR,
    output logic [NUM_RD*DATA_W-1:0] RDATA,
    input  logic                     CLR_REQ,
    output logic                     CLR_BUSY,
    output logic                     CLR_DONE
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_idx;
    logic              clr_stb;
    logic              acc0_c;
    logic              acc1_c;

    mp_reg_file_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk     (CLK),
        .reset   (RESET),
        .clr_req (CLR_REQ),
        .busy    (CLR_BUSY),
        .done    (CLR_DONE),
        .idx     (clr_idx),
        .clr_stb (clr_stb)
    );

    // A write is accepted only when idle, not in reset, and not aimed at a hardwired zero register.
    always_comb begin
        acc0_c = WE0 && !RESET && !CLR_BUSY && !((ZERO_REG != 0) && (WADDR0 == '0));
        acc1_c = WE1 && !RESET && !CLR_BUSY && !((ZERO_REG != 0) && (WADDR1 == '0));
    end

    // Storage update: reset, then sweep clear, then writes with port 1 winning collisions.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem <= '{default: '0};
        end else begin
            if (clr_stb) begin
                mem[clr_idx] <= '0;
            end
            if (acc0_c) begin
                mem[WADDR0] <= WDATA0;
            end
            if (acc1_c) begin
                mem[WADDR1] <= WDATA1;
            end
        end
    end

    // Combinational read lanes with optional forwarding of accepted same-cycle writes.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        RDATA = '0;
        ra    = '0;
        rv    = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = RADDR[k*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rv = '0;
            end else if ((BYPASS != 0) && acc1_c && (WADDR1 == ra)) begin
                rv = WDATA1;
            end else if ((BYPASS != 0) && acc0_c && (WADDR0 == ra)) begin
                rv = WDATA0;
            end else begin
                rv = mem[ra];
            end
            RDATA[k*DATA_W +: DATA_W] = rv;
        end
    end

endmodule

// File: tb/tb_mp_reg_file.sv
// Bench for mp_reg_file: two configurations driven in lockstep against a reference model.
module tb_mp_reg_file;

    logic        CLK;
    logic        RESET;
    logic        WE0, WE1;
    logic [2:0]  WADDR0, WADDR1;
    logic [7:0]  WDATA0, WDATA1;
    logic [5:0]  RADDR;
    logic        CLR_REQ;
    logic [15:0] rdata_a, rdata_b;
    logic        busy_a, done_a, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    // Reference: cfg 0 = BYPASS=1/ZERO_REG=0, cfg 1 = BYPASS=0/ZERO_REG=1.
    logic [7:0] m [2][8];
    int         age; // 0 idle, 1..8 clearing reg age-1 at next edge, 9 done cycle

    mp_reg_file u_a (
        .CLK(CLK), .RESET(RESET), .WE0(WE0), .WE1(WE1),
        .WADDR0(WADDR0), .WADDR1(WADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .RADDR(RADDR), .RDATA(rdata_a), .CLR_REQ(CLR_REQ),
        .CLR_BUSY(busy_a), .CLR_DONE(done_a)
    );

    mp_reg_file #(.BYPASS(0), .ZERO_REG(1)) u_b (
        .CLK(CLK), .RESET(RESET), .WE0(WE0), .WE1(WE1),
        .WADDR0(WADDR0), .WADDR1(WADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .RADDR(RADDR), .RDATA(rdata_b), .CLR_REQ(CLR_REQ),
        .CLR_BUSY(busy_b), .CLR_DONE(done_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit accepted(int c, int p);
        logic       we;
        logic [2:0] wa;
        we = (p == 1) ? WE1 : WE0;
        wa = (p == 1) ? WADDR1 : WADDR0;
        return we && !RESET && (age == 0) && !((c == 1) && (wa == 3'd0));
    endfunction

    function automatic logic [7:0] model_read(int c, logic [2:0] a);
        if (c == 1 && a == 3'd0) return 8'h00;
        if (c == 0 && accepted(c, 1) && WADDR1 == a) return WDATA1;
        if (c == 0 && accepted(c, 0) && WADDR0 == a) return WDATA0;
        return m[c][a];
    endfunction

    task automatic check_outputs();
        logic [2:0] a;
        logic [7:0] got;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 2; k++) begin
                a   = RADDR[k*3 +: 3];
                got = (c == 1) ? rdata_b[k*8 +: 8] : rdata_a[k*8 +: 8];
                chk($sformatf("rd_cfg%0d_lane%0d_addr%0d", c, k, a), 32'(got), 32'(model_read(c, a)));
            end
        end
        chk("busy_cfg0", 32'(busy_a), 32'(age != 0));
        chk("done_cfg0", 32'(done_a), 32'(age == 9));
        chk("busy_cfg1", 32'(busy_b), 32'(age != 0));
        chk("done_cfg1", 32'(done_b), 32'(age == 9));
    endtask

    task automatic update_model();
        bit a [2][2];
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 2; p++)
                a[c][p] = accepted(c, p);
        if (RESET) begin
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 8; r++)
                    m[c][r] = 8'h00;
            age = 0;
        end else begin
            if (age >= 1 && age <= 8) begin
                m[0][age-1] = 8'h00;
                m[1][age-1] = 8'h00;
            end
            for (int c = 0; c < 2; c++) begin
                if (a[c][0]) m[c][WADDR0] = WDATA0;
                if (a[c][1]) m[c][WADDR1] = WDATA1;
            end
            if (age == 0) age = CLR_REQ ? 1 : 0;
            else if (age == 9) age = 0;
            else age = age + 1;
        end
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        @(posedge CLK);
        update_model();
        @(negedge CLK);
    endtask

    task automatic quiet();
        RESET = 1'b0; WE0 = 1'b0; WE1 = 1'b0; CLR_REQ = 1'b0;
    endtask

    task automatic preload();
        quiet();
        for (int i = 0; i < 4; i++) begin
            WE0 = 1'b1; WADDR0 = 3'(2*i);     WDATA0 = 8'(8'h11 * (2*i + 1));
            WE1 = 1'b1; WADDR1 = 3'(2*i + 1); WDATA1 = 8'(8'h11 * (2*i + 2));
            RADDR = 6'($urandom);
            cycle();
        end
        quiet();
    endtask

    task automatic read_all();
        quiet();
        for (int i = 0; i < 4; i++) begin
            RADDR = {3'(2*i + 1), 3'(2*i)};
            cycle();
        end
    endtask

    initial begin
        int busy_cycles;
        int done_cycle;
        int done_count;

        age = 0;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 8; r++)
                m[c][r] = 8'hxx;
        RESET = 1'b1; WE0 = 1'b1; WE1 = 1'b1; CLR_REQ = 1'b1;
        WADDR0 = 3'd1; WADDR1 = 3'd5; WDATA0 = 8'h77; WDATA1 = 8'h99;
        RADDR = 6'd0;
        @(negedge CLK);
        @(posedge CLK);
        update_model();
        @(negedge CLK);

        // reset state: all registers zero, sweep not started despite CLR_REQ
        read_all();

        // write collision on address 2, same-cycle read on both lanes
        WE0 = 1'b1; WE1 = 1'b1; WADDR0 = 3'd2; WADDR1 = 3'd2;
        WDATA0 = 8'h5F; WDATA1 = 8'h1C; RADDR = {3'd2, 3'd2};
        cycle();
        quiet();
        cycle();
        chk("collision_reg2_cfg0", 32'(rdata_a[7:0]), 32'h1C);

        // zero register write of 0xAA
        WE0 = 1'b1; WADDR0 = 3'd0; WDATA0 = 8'hAA; RADDR = {3'd0, 3'd0};
        cycle();
        quiet();
        cycle();
        chk("zero_reg_cfg1", 32'(rdata_b[7:0]), 32'h00);

        // back-to-back write then read on lane 1
        WE0 = 1'b1; WADDR0 = 3'd4; WDATA0 = 8'h0F; RADDR = {3'd4, 3'd1};
        cycle();
        quiet();
        RADDR = {3'd4, 3'd0};
        cycle();
        chk("b2b_lane1_cfg0", 32'(rdata_a[15:8]), 32'h0F);

        // full sweep with a dropped write and an ignored second request
        preload();
        CLR_REQ = 1'b1; RADDR = {3'd4, 3'd3};
        cycle();
        CLR_REQ = 1'b0;
        busy_cycles = 0;
        done_cycle  = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) begin
                WE0 = 1'b1; WADDR0 = 3'd4; WDATA0 = 8'h06;
            end else begin
                WE0 = 1'b0;
            end
            CLR_REQ = (i == 5);
            RADDR = {3'($urandom), 3'd3};
            #1;
            if (busy_a) busy_cycles++;
            if (done_a) done_cycle = i;
            cycle();
        end
        chk("sweep_busy_cycles", 32'(busy_cycles), 32'd9);
        chk("sweep_done_cycle", 32'(done_cycle), 32'd9);
        read_all();

        // reset during the fourth sweep cycle aborts without a done pulse
        preload();
        CLR_REQ = 1'b1;
        cycle();
        CLR_REQ = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            RADDR = 6'($urandom);
            cycle();
        end
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        done_count = 0;
        for (int i = 0; i < 12; i++) begin
            RADDR = 6'($urandom);
            #1;
            if (done_a || done_b) done_count++;
            cycle();
        end
        chk("abort_done_pulses", 32'(done_count), 32'd0);
        read_all();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            RESET   = ($urandom_range(0, 60) == 0);
            CLR_REQ = ($urandom_range(0, 25) == 0);
            WE0     = 1'($urandom);
            WE1     = 1'($urandom);
            WADDR0  = 3'($urandom);
            WADDR1  = ($urandom_range(0, 3) == 0) ? WADDR0 : 3'($urandom);
            WDATA0  = 8'($urandom);
            WDATA1  = 8'($urandom);
            RADDR   = ($urandom_range(0, 2) == 0) ? {WADDR1, WADDR0} : 6'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mp_reg_file.md
MP_REG_FILE -- requirements
Module: mp_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports.
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL have parameter ZERO_REG, default 0, 1 = register 0 hardwired to zero.
REQ-006 SHALL have port CLK  input  1  clock, all state updates on rising edge.
REQ-007 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports WE0/WE1  input  1 each  write enables, ports 0 and 1.
REQ-009 SHALL have ports WADDR0/WADDR1  input  ADDR_W each  write addresses.
REQ-010 SHALL have ports WDATA0/WDATA1  input  DATA_W each  write data.
REQ-011 SHALL have port RADDR  input  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port RDATA  output  NUM_RD*DATA_W  packed read data, same packing.
REQ-013 SHALL have port CLR_REQ  input  1  one-cycle request for a background clear.
REQ-014 SHALL have port CLR_BUSY  output  1  high while a clear sweep is running.
REQ-015 SHALL have port CLR_DONE  output  1  one-cycle pulse when a sweep completes.

Function
REQ-016 Reads SHALL be combinational, zero-cycle, with no delay constructs.
REQ-017 Writes SHALL commit on the rising CLK edge when WEx=1, RESET=0 and FSM is IDLE.
REQ-018 When WE0 and WE1 target the same address in one cycle, port 1 data SHALL be stored.
REQ-019 With BYPASS=1, a read matching an accepted same-cycle write address SHALL return that write's data, port 1 first; with BYPASS=0 it SHALL return the stored value.
REQ-020 With ZERO_REG=1, reads of address 0 SHALL return 0, writes to address 0 SHALL be discarded, and no bypass SHALL apply to address 0.
REQ-021 The clear FSM SHALL have states IDLE, SWEEP, DONE.
REQ-022 IDLE->SWEEP on CLR_REQ=1 and RESET=0; the index counter SHALL load 0.
REQ-023 In SWEEP, each edge SHALL zero register[index] and increment index; after index DEPTH-1 it SHALL go to DONE. A sweep takes exactly DEPTH cycles.
REQ-024 DONE SHALL last one cycle with CLR_DONE=1, then return to IDLE.
REQ-025 CLR_BUSY SHALL be 1 in SWEEP and DONE, else 0.
REQ-026 Writes in SWEEP or DONE SHALL be dropped. Bypass SHALL be inhibited in those states.
REQ-027 CLR_REQ SHALL be ignored outside IDLE.
REQ-028 Reads during a sweep SHALL return current stored contents: zero for indexes already cleared, the old value otherwise.

Reset
REQ-029 On an edge with RESET=1, all DEPTH registers SHALL become 0. The FSM SHALL go to IDLE and the index to 0.
REQ-030 Reset SHALL take priority over writes, CLR_REQ, and an in-progress sweep. An aborted sweep SHALL produce no CLR_DONE pulse.
REQ-031 After reset, CLR_BUSY=0, CLR_DONE=0, and every RDATA lane SHALL read 0.

Structure
REQ-032 Package mp_reg_file_pkg SHALL hold the FSM state enumeration and default DATA_W/ADDR_W/NUM_RD constants.
REQ-033 The clear FSM and index counter SHALL be a sub-module mp_reg_file_clr_fsm. It SHALL output busy, done, the sweep index and a clear strobe.
REQ-034 The storage array, write arbitration and read/bypass muxing SHALL stay in mp_reg_file.

Verification (DATA_W=8, ADDR_W=3, NUM_RD=2)
REQ-035 Reset check: RESET=1 for one edge, then read addresses 0..7 -> all 0x00, CLR_BUSY=0.
REQ-036 Write collision: WE0=WE1=1, both WADDR=2, WDATA0=0x5F, WDATA1=0x1C -> reg2=0x1C after the edge; same-cycle read of 2 shows 0x1C (BYPASS=1) or the old value (BYPASS=0).
REQ-037 Zero register: ZERO_REG=1, write 0xAA to address 0 -> address 0 reads 0x00 in the same cycle and after.
REQ-038 Sweep: registers 0..7 preloaded with 0x11..0x88, CLR_REQ pulse -> CLR_BUSY high for 9 cycles. Reg3 reads 0x44 until its clear edge, then 0x00. CLR_DONE pulses on cycle 9. A write of 0x06 to reg4 mid-sweep is dropped.
REQ-039 Reset mid-sweep: RESET at sweep cycle 4 -> all registers 0x00, CLR_BUSY=0 next cycle, no CLR_DONE.
REQ-040 Back-to-back: write 0x0F to reg4, then read reg4 on port 1 the next cycle -> 0x0F, independent of BYPASS.
